spi_slave_port: RTL and testbench
=================================

SPI_SLAVE_PORT -- requirements
Module: spi_slave_port

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of flops in each of the SCLK, MOSI and SS_n input synchronizers (legal 2..3).
REQ-002 Ports, clock and reset first:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- SCLK  in  1  SPI clock from the external master, asynchronous to clk.
- MOSI  in  1  serial data from the master.
- SS_n  in  1  slave select, active low.
- MISO  out  1  serial data to the master.
- MISO_oe  out  1  MISO output enable, for the top-level tristate.
- spi_select  in  1  register-port chip select.
- mem_addr  in  3  register address.
- read_n  in  1  read strobe, active low.
- write_n  in  1  write strobe, active low.
- data_from_cpu  in  16  write data.
- data_to_cpu  out  16  registered read data.
- irq  out  1  registered interrupt.
REQ-003 The block SHALL have one clock and SHALL use a synchronous, active-high reset.

Function
REQ-004 SPI format SHALL be fixed: mode 0 (CPOL=0, CPHA=0), 8-bit frames, MSB first.
REQ-005 SCLK, MOSI and SS_n SHALL each pass through a SYNC_STAGES synchronizer; edge detection SHALL use the last synchronized stage against one further delay flop.
REQ-006 Supported SCLK frequency SHALL be at most clk/8; behaviour above that is undefined.
REQ-007 Register map:
- addr 0: rx data (R).
- addr 1: tx data (W).
- addr 2: status (R; any write clears ROE, TOE and TUE).
- addr 3: control (R/W).
- other addresses read 0; writes to them are ignored.
REQ-008 Status bits: [3] ROE, [4] TOE, [5] TUE, [6] TRDY, [7] RRDY, [8] E = ROE|TOE|TUE; all other bits read 0.
REQ-009 Control bits: [3] iROE, [4] iTOE, [5] iTUE, [6] iTRDY, [7] iRRDY, [8] iE; all other bits read 0.
REQ-010 Read access: a cycle with spi_select & ~read_n SHALL present the addressed value on data_to_cpu on the next clk edge (1-cycle latency). A read of addr 0 SHALL clear RRDY in that same cycle.
REQ-011 Write access: a cycle with spi_select & ~write_n SHALL take effect at that clk edge.
- Tx-data write with TRDY=1: data_from_cpu[7:0] goes to tx_holding and tx_primed is set.
- Tx-data write with TRDY=0: the data is dropped and TOE is set.
REQ-012 TRDY SHALL equal ~tx_primed, evaluated before any same-cycle load.
REQ-013 Frame start (synchronized SS_n falling):
- bit counter is set to 0 and MISO_oe to 1;
- shift_tx loads tx_holding and tx_primed is cleared if tx_primed=1;
- otherwise shift_tx loads 0x00 and TUE is set.
REQ-014 MISO SHALL equal shift_tx[7] while MISO_oe=1, and 0 otherwise.
REQ-015 On each synchronized SCLK rising edge with SS_n low:
- shift_rx <= {shift_rx[6:0], MOSI_sync};
- bit counter increments modulo 8.
REQ-016 On each synchronized SCLK falling edge with SS_n low and bit counter != 0, shift_tx SHALL shift left by one bit.
REQ-017 Byte completion (the rising edge that wraps the bit counter from 7 to 0):
- rx_holding <= assembled byte;
- ROE is set if RRDY was already 1;
- RRDY is set;
- shift_tx reloads under the REQ-013 rule, so back-to-back bytes need no SS_n toggle.
REQ-018 The falling edge that follows byte completion SHALL NOT shift shift_tx (bit counter is 0).
REQ-019 Synchronized SS_n rising mid-byte:
- the partial byte is discarded;
- bit counter is set to 0 and MISO_oe to 0;
- RRDY and rx_holding are unchanged.
REQ-020 Simultaneous events:
- byte completion in the same cycle as an addr-0 read: RRDY ends at 1 and ROE is not set;
- flag set in the same cycle as a status write: the set wins;
- tx write in the same cycle as a load with tx_primed=0: the load sends 0x00 (TUE set) and the write primes tx_holding for the next byte.
REQ-021 irq SHALL be registered as (ROE&iROE)|(TOE&iTOE)|(TUE&iTUE)|(TRDY&iTRDY)|(RRDY&iRRDY)|(E&iE).

Reset
REQ-022 When reset=1 at a clk edge, all state SHALL clear with these values:
- MISO=0, MISO_oe=0, irq=0, data_to_cpu=0;
- RRDY, ROE, TOE, TUE, tx_primed, the control register, both shift registers, rx_holding, tx_holding and the bit counter all 0;
- synchronizers set to the idle values SS_n=1, SCLK=0.
REQ-023 A reset asserted mid-frame SHALL abort the frame, with no RRDY set afterwards; after reset the block SHALL wait for a fresh SS_n falling edge.

Verification
REQ-024 Write 0xA5 to tx, then master sends 0x3C (SCLK=clk/8) -> master receives 0xA5; after the frame rx=0x3C, RRDY=1, TRDY=1.
REQ-025 Two back-to-back bytes 0x11 then 0x22 without reading rx -> rx=0x22 and ROE=1; with iROE=1, irq goes to 1 one cycle later.
REQ-026 SS_n falls with no tx written -> MISO sends 0x00, TUE=1; a status write then clears TUE.
REQ-027 Write tx 0x55 then tx 0x66 before any frame -> TOE=1; the master receives 0x55.
REQ-028 SS_n rises after 5 bits, then a full frame with master byte 0xC3 -> only one RRDY event, rx=0xC3.
REQ-029 Assert reset after 4 bits -> all outputs and status return to reset values; the next full frame completes normally.

Source files
------------

// File: rtl/spi_slave_port.sv
// SPI mode-0 slave with a CPU-visible register port.
// SCLK/MOSI/SS_n are resynchronized into the clk domain; all state, including the
// serializer, runs on clk.
module spi_slave_port #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        SS_n,
  output logic        MISO,
  output logic        MISO_oe,
  input  logic        spi_select,
  input  logic [2:0]  mem_addr,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        irq
);

  // Synchronizer chains; index SYNC_STAGES-1 is the settled stage.
  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic                   sclk_dly, ss_dly;

  logic [7:0] shift_rx, shift_tx, rx_holding, tx_holding;
  logic [2:0] bit_cnt;
  logic       tx_primed, rrdy, roe, toe, tue;
  logic [5:0] ctrl;

  logic sclk_s, mosi_s, ss_s;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic byte_done, load;
  logic rd, wr, rx_rd, tx_wr, st_wr, ctl_wr;
  logic trdy, err;
  logic [7:0]  rx_next;
  logic [15:0] status_word, ctrl_word, rd_data;
  logic        irq_next;
  logic        unused_data_hi;

  assign unused_data_hi = ^data_from_cpu[15:9];

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_dly;
  assign sclk_fall = ~sclk_s & sclk_dly;
  assign ss_fall   = ~ss_s & ss_dly;
  assign ss_rise   = ss_s & ~ss_dly;

  // Frame start takes priority over a coincident SCLK edge.
  assign byte_done = sclk_rise & ~ss_s & ~ss_fall & (bit_cnt == 3'd7);
  assign load      = ss_fall | byte_done;
  assign rx_next   = {shift_rx[6:0], mosi_s};

  assign rd     = spi_select & ~read_n;
  assign wr     = spi_select & ~write_n;
  assign rx_rd  = rd & (mem_addr == 3'd0);
  assign tx_wr  = wr & (mem_addr == 3'd1);
  assign st_wr  = wr & (mem_addr == 3'd2);
  assign ctl_wr = wr & (mem_addr == 3'd3);

  assign trdy        = ~tx_primed;
  assign err         = roe | toe | tue;
  assign status_word = {7'd0, err, rrdy, trdy, tue, toe, roe, 3'd0};
  assign ctrl_word   = {7'd0, ctrl, 3'd0};

  assign MISO = MISO_oe & shift_tx[7];

  // Read-data mux and interrupt term, both from pre-update state.
  always_comb begin
    rd_data = 16'd0;
    case (mem_addr)
      3'd0:    rd_data = {8'd0, rx_holding};
      3'd2:    rd_data = status_word;
      3'd3:    rd_data = ctrl_word;
      default: rd_data = 16'd0;
    endcase
    irq_next = (roe & ctrl[0]) | (toe & ctrl[1]) | (tue & ctrl[2]) |
               (trdy & ctrl[3]) | (rrdy & ctrl[4]) | (err & ctrl[5]);
  end

  // All state: synchronizers, register port, serializer and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync   <= '0;
      mosi_sync   <= '0;
      ss_sync     <= '1;
      sclk_dly    <= 1'b0;
      ss_dly      <= 1'b1;
      shift_rx    <= 8'd0;
      shift_tx    <= 8'd0;
      rx_holding  <= 8'd0;
      tx_holding  <= 8'd0;
      bit_cnt     <= 3'd0;
      tx_primed   <= 1'b0;
      rrdy        <= 1'b0;
      roe         <= 1'b0;
      toe         <= 1'b0;
      tue         <= 1'b0;
      ctrl        <= 6'd0;
      MISO_oe     <= 1'b0;
      data_to_cpu <= 16'd0;
      irq         <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
      sclk_dly  <= sclk_s;
      ss_dly    <= ss_s;

      if (rd) data_to_cpu <= rd_data;
      irq <= irq_next;
      if (ctl_wr) ctrl <= data_from_cpu[8:3];

      // Clears first so that any flag set later in this block wins.
      if (st_wr) begin
        roe <= 1'b0;
        toe <= 1'b0;
        tue <= 1'b0;
      end
      if (rx_rd) rrdy <= 1'b0;

      if (tx_wr) begin
        if (tx_primed) begin
          toe <= 1'b1;
        end else begin
          tx_holding <= data_from_cpu[7:0];
          tx_primed  <= 1'b1;
        end
      end

      if (ss_fall) begin
        bit_cnt <= 3'd0;
        MISO_oe <= 1'b1;
      end else if (ss_rise) begin
        bit_cnt <= 3'd0;
        MISO_oe <= 1'b0;
      end else if (~ss_s) begin
        if (sclk_rise) begin
          shift_rx <= rx_next;
          bit_cnt  <= bit_cnt + 3'd1;
        end
        // bit_cnt==0 means the MSB was just loaded and must not be skipped.
        if (sclk_fall && bit_cnt != 3'd0) shift_tx <= {shift_tx[6:0], 1'b0};
      end

      if (byte_done) begin
        rx_holding <= rx_next;
        rrdy       <= 1'b1;
        if (rrdy & ~rx_rd) roe <= 1'b1;
      end

      // Underrun sends zeros; a same-cycle tx write still primes the next byte.
      if (load) begin
        if (tx_primed) begin
          shift_tx  <= tx_holding;
          tx_primed <= 1'b0;
        end else begin
          shift_tx <= 8'd0;
          tue      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_port.sv
module tb_spi_slave_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        SCLK = 1'b0, MOSI = 1'b0, SS_n = 1'b1;
  logic        MISO, MISO_oe, irq;
  logic        spi_select = 1'b0, read_n = 1'b1, write_n = 1'b1;
  logic [2:0]  mem_addr = 3'd0;
  logic [15:0] data_from_cpu = 16'd0;
  logic [15:0] data_to_cpu;

  always #5 clk = ~clk;

  spi_slave_port #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .MOSI(MOSI), .SS_n(SS_n),
    .MISO(MISO), .MISO_oe(MISO_oe), .spi_select(spi_select), .mem_addr(mem_addr),
    .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu),
    .data_to_cpu(data_to_cpu), .irq(irq)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] rd_exp_q[$];
  logic [7:0]  miso_exp_q[$];
  logic [7:0]  miso_got_q[$];

  // Reference model: register-level view of the slave.
  bit [7:0] m_rx, m_hold;
  bit       m_rrdy, m_roe, m_toe, m_tue, m_primed;
  bit [5:0] m_ctrl;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [15:0] m_status();
    logic [15:0] s = 16'd0;
    s[3] = m_roe; s[4] = m_toe; s[5] = m_tue; s[6] = ~m_primed; s[7] = m_rrdy;
    s[8] = m_roe | m_toe | m_tue;
    return s;
  endfunction

  function automatic logic m_irq();
    return (m_roe & m_ctrl[0]) | (m_toe & m_ctrl[1]) | (m_tue & m_ctrl[2]) |
           (~m_primed & m_ctrl[3]) | (m_rrdy & m_ctrl[4]) |
           ((m_roe | m_toe | m_tue) & m_ctrl[5]);
  endfunction

  task automatic m_clear();
    m_rx = 0; m_hold = 0; m_rrdy = 0; m_roe = 0; m_toe = 0; m_tue = 0;
    m_primed = 0; m_ctrl = 0;
  endtask

  // Transmit byte chosen whenever the slave starts a byte slot.
  task automatic m_load(output logic [7:0] b);
    if (m_primed) begin b = m_hold; m_primed = 0; end
    else begin b = 8'h00; m_tue = 1; end
  endtask

  task automatic m_byte_received(input logic [7:0] b);
    if (m_rrdy) m_roe = 1;
    m_rx = b; m_rrdy = 1;
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    spi_select = 1; write_n = 0; mem_addr = a; data_from_cpu = d;
    case (a)
      3'd1: if (m_primed) m_toe = 1; else begin m_hold = d[7:0]; m_primed = 1; end
      3'd2: begin m_roe = 0; m_toe = 0; m_tue = 0; end
      3'd3: m_ctrl = d[8:3];
      default: ;
    endcase
    @(negedge clk);
    spi_select = 0; write_n = 1;
  endtask

  task automatic cpu_read(input logic [2:0] a);
    @(negedge clk);
    spi_select = 1; read_n = 0; mem_addr = a;
    case (a)
      3'd0: begin rd_exp_q.push_back({8'd0, m_rx}); m_rrdy = 0; end
      3'd2: rd_exp_q.push_back(m_status());
      3'd3: rd_exp_q.push_back({7'd0, m_ctrl, 3'd0});
      default: rd_exp_q.push_back(16'd0);
    endcase
    @(negedge clk);
    spi_select = 0; read_n = 1;
  endtask

  task automatic check_irq();
    repeat (2) @(negedge clk);
    check("irq", {15'd0, irq}, {15'd0, m_irq()});
  endtask

  // Master side, SCLK = clk/8, mode 0.
  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] got);
    got = 8'd0;
    for (int i = 7; i > 7 - nbits; i--) begin
      MOSI = mo[i];
      repeat (4) @(negedge clk);
      SCLK = 1;
      got[i] = MISO;
      repeat (4) @(negedge clk);
      SCLK = 0;
    end
  endtask

  task automatic spi_frame(input int n, input logic [7:0] d0, input logic [7:0] d1);
    logic [7:0] e, got;
    @(negedge clk);
    SS_n = 0;
    m_load(e);
    miso_exp_q.push_back(e);
    repeat (8) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      spi_bits((k == 0) ? d0 : d1, 8, got);
      miso_got_q.push_back(got);
      m_byte_received((k == 0) ? d0 : d1);
      m_load(e);
      if (k < n - 1) miso_exp_q.push_back(e);
    end
    repeat (4) @(negedge clk);
    SS_n = 1;
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_partial(input int nbits, input logic [7:0] d);
    logic [7:0] e, got;
    @(negedge clk);
    SS_n = 0;
    m_load(e);
    repeat (8) @(negedge clk);
    spi_bits(d, nbits, got);
    repeat (4) @(negedge clk);
    SS_n = 1;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, {15'd0, MISO}, 16'd0);
    check({tag, "_miso_oe"}, {15'd0, MISO_oe}, 16'd0);
    check({tag, "_irq"}, {15'd0, irq}, 16'd0);
    check({tag, "_dout"}, data_to_cpu, 16'd0);
  endtask

  // Read-data monitor: any accepted read presents its value one edge later.
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge clk);
      if (spi_select === 1'b1 && read_n === 1'b0) begin
        #1;
        if (rd_exp_q.size() == 0) begin
          check("rd_unexpected", data_to_cpu, 16'hxxxx);
        end else begin
          e = rd_exp_q.pop_front();
          check("rd_data", data_to_cpu, e);
        end
      end
    end
  end

  // MISO monitor: compares each byte the master collected.
  initial begin
    logic [7:0] g, e;
    forever begin
      @(posedge clk);
      while (miso_got_q.size() > 0) begin
        g = miso_got_q.pop_front();
        if (miso_exp_q.size() == 0) begin
          check("miso_unexpected", {8'd0, g}, 16'hxxxx);
        end else begin
          e = miso_exp_q.pop_front();
          check("miso_byte", {8'd0, g}, {8'd0, e});
        end
      end
    end
  end

  initial begin
    logic [7:0] got;
    m_clear();
    repeat (4) @(negedge clk);
    reset = 0;
    @(negedge clk);
    check_reset_outputs("reset");
    cpu_read(3'd2);
    cpu_read(3'd3);
    cpu_read(3'd0);

    // Basic exchange.
    cpu_write(3'd1, 16'h00A5);
    spi_frame(1, 8'h3C, 8'h00);
    cpu_read(3'd2);
    cpu_read(3'd0);
    cpu_write(3'd2, 16'h0000);
    cpu_read(3'd2);

    // Back-to-back overrun with iROE.
    cpu_write(3'd3, 16'h0008);
    spi_frame(2, 8'h11, 8'h22);
    check_irq();
    cpu_read(3'd0);
    cpu_read(3'd2);
    cpu_write(3'd2, 16'h0000);
    cpu_write(3'd3, 16'h0000);

    // Underrun.
    spi_frame(1, 8'h5A, 8'h00);
    cpu_read(3'd2);
    cpu_write(3'd2, 16'h0000);
    cpu_read(3'd2);

    // Tx overrun keeps the first byte.
    cpu_write(3'd1, 16'h0055);
    cpu_write(3'd1, 16'h0066);
    cpu_read(3'd2);
    spi_frame(1, 8'h81, 8'h00);

    // Aborted partial byte, then full frame.
    cpu_read(3'd0);
    cpu_write(3'd2, 16'h0000);
    spi_partial(5, 8'hFF);
    cpu_read(3'd2);
    spi_frame(1, 8'hC3, 8'h00);
    cpu_read(3'd2);
    cpu_read(3'd0);

    // Reset mid-frame.
    cpu_write(3'd3, 16'h01F8);
    cpu_write(3'd1, 16'h009A);
    @(negedge clk);
    SS_n = 0;
    repeat (8) @(negedge clk);
    spi_bits(8'hE7, 4, got);
    reset = 1; SCLK = 0; SS_n = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    m_clear();
    repeat (4) @(negedge clk);
    check_reset_outputs("midreset");
    cpu_read(3'd2);
    cpu_read(3'd3);
    cpu_write(3'd1, 16'h005B);
    spi_frame(1, 8'h77, 8'h00);
    cpu_read(3'd0);

    // Randomized traffic.
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 6))
        0: cpu_write(3'd1, 16'($urandom));
        1: spi_frame($urandom_range(1, 2), 8'($urandom), 8'($urandom));
        2: cpu_read(3'($urandom_range(0, 7)));
        3: cpu_write(3'd2, 16'($urandom));
        4: begin cpu_write(3'd3, 16'($urandom)); check_irq(); end
        5: spi_partial($urandom_range(1, 7), 8'($urandom));
        default: begin cpu_write(3'($urandom_range(4, 7)), 16'($urandom)); cpu_read(3'd2); end
      endcase
    end
    check_irq();
    cpu_read(3'd2);

    repeat (10) @(negedge clk);
    check("rd_queue_drained", 16'(rd_exp_q.size()), 16'd0);
    check("miso_queue_drained", 16'(miso_exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
